// File: rtl/gc_pkg.sv
// gc_pkg: shared state encoding and default parameters for the gc_imp C-element cell.
package gc_pkg;
    typedef enum logic [1:0] {OFF, RISE, ON, FALL} gc_state_t;
    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_SETTLE_CYCLES = 4;
endpackage

// File: rtl/gc_sync.sv
// gc_sync: N-stage single-bit synchronizer with synchronous active-high reset.
// Ports: clk, rst; d (asynchronous input); q (synchronized output).
module gc_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [N-1:0] ff;
    always_ff @(posedge clk) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff[0] <= d;
            for (int i = 1; i < N; i++) ff[i] <= ff[i-1];
        end
    end
    assign q = ff[N-1];
endmodule

// File: rtl/gc_imp.sv
// gc_imp: clocked generalized C-element; Actuator sets after sustained Start&Sensor, clears after sustained ~Start&~Sensor.
// Ports: clk, rst (sync, active-high); Start, Sensor (asynchronous inputs); Actuator (registered output).
module gc_imp
    import gc_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic Start,
    input  logic Sensor,
    output logic Actuator
);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] CMAX = CW'(SETTLE_CYCLES);
    localparam bit DIRECT = (SETTLE_CYCLES == 1);

    logic start_s, sensor_s, set_c, clr_c;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    gc_state_t state, state_n;

    gc_sync #(.N(SYNC_STAGES)) u_sync_start  (.clk(clk), .rst(rst), .d(Start),  .q(start_s));
    gc_sync #(.N(SYNC_STAGES)) u_sync_sensor (.clk(clk), .rst(rst), .d(Sensor), .q(sensor_s));

    assign set_c   = start_s & sensor_s;
    assign clr_c   = ~start_s & ~sensor_s;
    assign cnt_inc = (cnt == CMAX) ? cnt : cnt + 1'b1;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            OFF: if (set_c) begin
                state_n = DIRECT ? ON : RISE;
                cnt_n   = DIRECT ? '0 : CW'(1);
            end
            RISE: if (!set_c) begin
                state_n = OFF;
                cnt_n   = '0;
            end else begin
                state_n = (cnt_inc == CMAX) ? ON : RISE;
                cnt_n   = (cnt_inc == CMAX) ? '0 : cnt_inc;
            end
            ON: if (clr_c) begin
                state_n = DIRECT ? OFF : FALL;
                cnt_n   = DIRECT ? '0 : CW'(1);
            end
            FALL: if (!clr_c) begin
                state_n = ON;
                cnt_n   = '0;
            end else begin
                state_n = (cnt_inc == CMAX) ? OFF : FALL;
                cnt_n   = (cnt_inc == CMAX) ? '0 : cnt_inc;
            end
            default: begin
                state_n = OFF;
                cnt_n   = '0;
            end
        endcase
    end

    // Actuator is a flop of the decoded current state, so it can never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= OFF;
            cnt      <= '0;
            Actuator <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            Actuator <= (state == ON) || (state == FALL);
        end
    end
endmodule

// File: tb/tb_gc_imp.sv
module tb_gc_imp;
    import gc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b1;
    logic sensor = 1'b1;
    logic a1, a2, a3, a4;

    always #5 clk = ~clk;

    gc_imp dut (.clk(clk), .rst(rst), .Start(start), .Sensor(sensor), .Actuator(a1));
    gc_imp u2  (.clk(clk), .rst(rst), .Start(a1),    .Sensor(sensor), .Actuator(a2));
    gc_imp u3  (.clk(clk), .rst(rst), .Start(a2),    .Sensor(sensor), .Actuator(a3));
    gc_imp #(.SYNC_STAGES(1), .SETTLE_CYCLES(1)) u4
               (.clk(clk), .rst(rst), .Start(start), .Sensor(sensor), .Actuator(a4));

    typedef struct {
        string      tag;
        logic [3:0] v;
        logic [3:0] m;
    } exp_t;

    exp_t  sb[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    string tag = "init";

    task automatic push(input int n, input logic [3:0] v, input logic [3:0] m);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        e.m   = m;
        repeat (n) sb.push_back(e);
    endtask

    task automatic run(input int n);
        exp_t e;
        logic [3:0] act;
        repeat (n) begin
            @(posedge clk);
            #1;
            act = {a4, a3, a2, a1};
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $error("FAIL %s scoreboard empty actual=%b", tag, act);
            end else begin
                e = sb.pop_front();
                assert ((act & e.m) === (e.v & e.m)) else begin
                    n_fail++;
                    $error("FAIL %s actuators=%b expected=%b mask=%b", e.tag, act, e.v, e.m);
                end
            end
        end
    endtask

    task automatic chk(input string t, input int got, input int exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%0d expected=%0d", t, got, exp);
        end
    endtask

    initial begin
        tag = "reset";
        push(2, 4'b0000, 4'b1111);
        run(2);
        chk("reset_state", dut.state, OFF);
        chk("reset_cnt", dut.cnt, 0);

        tag = "basic_set";
        rst = 1'b0; start = 1'b0; sensor = 1'b1;
        push(5, 4'b0000, 4'b0001);
        run(5);
        start = 1'b1;
        push(6, 4'b0000, 4'b0001);
        push(3, 4'b0001, 4'b0001);
        run(9);

        tag = "hold_mixed";
        start = 1'b0;
        push(20, 4'b0001, 4'b0001);
        run(20);

        tag = "fall";
        sensor = 1'b0;
        push(6, 4'b0001, 4'b0001);
        push(3, 4'b0000, 4'b0001);
        run(9);

        tag = "glitch";
        sensor = 1'b1;
        push(4, 4'b0000, 4'b0001);
        run(4);
        start = 1'b1;
        push(3, 4'b0000, 4'b0001);
        run(3);
        start = 1'b0;
        push(10, 4'b0000, 4'b0001);
        run(10);

        tag = "glitch_then_hold";
        start = 1'b1;
        push(6, 4'b0000, 4'b0001);
        push(3, 4'b0001, 4'b0001);
        run(9);

        tag = "chain_reset";
        rst = 1'b1; start = 1'b0; sensor = 1'b1;
        push(2, 4'b0000, 4'b0111);
        run(2);
        rst = 1'b0;
        push(3, 4'b0000, 4'b0111);
        run(3);

        tag = "chain_rise";
        start = 1'b1;
        push(6, 4'b0000, 4'b0111);
        push(7, 4'b0001, 4'b0111);
        push(7, 4'b0011, 4'b0111);
        push(5, 4'b0111, 4'b0111);
        run(25);

        tag = "chain_hold";
        start = 1'b0;
        push(10, 4'b0111, 4'b0111);
        run(10);

        tag = "chain_fall";
        sensor = 1'b0;
        push(6, 4'b0111, 4'b0111);
        push(7, 4'b0110, 4'b0111);
        push(7, 4'b0100, 4'b0111);
        push(5, 4'b0000, 4'b0111);
        run(25);

        tag = "mid_rise";
        start = 1'b1; sensor = 1'b1;
        push(4, 4'b0000, 4'b0001);
        run(4);
        chk("mid_rise_cnt", dut.cnt, 2);
        chk("mid_rise_state", dut.state, RISE);
        rst = 1'b1;
        push(1, 4'b0000, 4'b1111);
        run(1);
        chk("mid_rise_reset_cnt", dut.cnt, 0);
        chk("mid_rise_reset_state", dut.state, OFF);

        tag = "restart";
        rst = 1'b0;
        push(2, 4'b0000, 4'b1001);
        push(4, 4'b1000, 4'b1001);
        push(3, 4'b1001, 4'b1001);
        run(9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
